// File: rtl/aes_pkg.sv
// Shared constants for the AES round-key scheduler: schedule geometry,
// byte/index widths and the controller state encoding.
package aes_pkg;

    localparam int NR        = 10;   // expanded round keys (store holds NR+1)
    localparam int KEY_BYTES = 16;   // bytes per round key
    localparam int BYTE_W    = 8;
    localparam int ROUND_W   = 4;    // round index width (0..15)
    localparam int BIDX_W    = 4;    // byte-within-key index width

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_EXPAND = 3'd2;
    localparam logic [2:0] ST_READY  = 3'd3;
    localparam logic [2:0] ST_SERVE  = 3'd4;

endpackage

// File: rtl/aes_rk_store.sv
// Round-key store: (NUM_ROUNDS+1) keys of KEY_BYTES bytes each, one byte write
// port and one byte read port with a registered read. Byte 0 of a key is its
// most significant byte. Contents are not reset.
module aes_rk_store
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ROUND_W-1:0] wr_round,
    input  logic [BIDX_W-1:0]  wr_idx,
    input  logic [BYTE_W-1:0]  wr_data,
    input  logic [ROUND_W-1:0] rd_round,
    input  logic [BIDX_W-1:0]  rd_idx,
    output logic [BYTE_W-1:0]  rd_data
);

    localparam int DEPTH = (NUM_ROUNDS + 1) * KEY_BYTES;

    logic [BYTE_W-1:0] mem [0:DEPTH-1];

    // With 16-byte keys the flat address is simply {round, byte index}.
    logic [ROUND_W+BIDX_W-1:0] wr_addr;
    logic [ROUND_W+BIDX_W-1:0] rd_addr;

    assign wr_addr = {wr_round, wr_idx};
    assign rd_addr = {rd_round, rd_idx};

    // Byte write and registered byte read, shaped for block-RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/aes_round_key_scheduler.sv
// AES round-key scheduler: captures the cipher key byte-serially, drives the
// byte-serial expansion unit, buffers the expanded schedule and serves any
// round key byte-serially (MSB byte first) with one cycle of latency.
module aes_round_key_scheduler #(
    parameter int NR        = 10,
    parameter int KEY_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_byte,
    input  logic       key_valid,
    output logic       key_ready,
    output logic [7:0] ke_key_byte,
    output logic       ke_load,
    output logic       ke_start,
    input  logic [7:0] ke_byte,
    input  logic       ke_valid,
    input  logic       rk_req,
    input  logic [3:0] rk_round,
    output logic [7:0] rk_byte,
    output logic       rk_valid,
    output logic       rk_last,
    output logic       rk_err,
    output logic       keys_valid,
    output logic       busy
);

    import aes_pkg::*;

    localparam logic [7:0] EXP_LAST  = 8'(NR * KEY_BYTES - 1);
    localparam logic [3:0] MAX_ROUND = 4'(NR);

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic [3:0] key_cnt_reg;
    logic [7:0] exp_cnt_reg;
    logic [3:0] srv_cnt_reg;
    logic [3:0] srv_round_reg;
    logic [7:0] ke_key_byte_reg;
    logic       ke_load_reg;
    logic       ke_start_reg;
    logic       rk_err_reg;

    logic       key_fire;
    logic       exp_fire;
    logic       req_ok;

    logic       st_wr_en;
    logic [3:0] st_wr_round;
    logic [3:0] st_wr_idx;
    logic [7:0] st_wr_data;
    logic [3:0] st_rd_round;
    logic [3:0] st_rd_idx;
    logic [7:0] st_rd_data;

    assign key_ready  = (state_reg == ST_IDLE) || (state_reg == ST_LOAD) || (state_reg == ST_READY);
    assign keys_valid = (state_reg == ST_READY) || (state_reg == ST_SERVE);
    assign busy       = (state_reg == ST_LOAD) || (state_reg == ST_EXPAND);
    assign rk_valid   = (state_reg == ST_SERVE);
    assign rk_last    = rk_valid && (srv_cnt_reg == 4'd15);
    assign rk_byte    = rk_valid ? st_rd_data : 8'h00;
    assign rk_err     = rk_err_reg;
    assign ke_key_byte = ke_key_byte_reg;
    assign ke_load    = ke_load_reg;
    assign ke_start   = ke_start_reg;

    assign key_fire = key_valid && key_ready;
    assign exp_fire = ke_valid && (state_reg == ST_EXPAND);
    // A key byte offered in READY takes priority over a round-key request.
    assign req_ok   = (state_reg == ST_READY) && !key_fire && rk_req && (rk_round <= MAX_ROUND);

    // Next-state logic for the load / expand / serve sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (key_fire) state_next = ST_LOAD;
            ST_LOAD:   if (key_fire && key_cnt_reg == 4'd15) state_next = ST_EXPAND;
            ST_EXPAND: if (exp_fire && exp_cnt_reg == EXP_LAST) state_next = ST_READY;
            ST_READY: begin
                if (key_fire) begin
                    state_next = ST_LOAD;
                end else if (req_ok) begin
                    state_next = ST_SERVE;
                end
            end
            ST_SERVE:  if (srv_cnt_reg == 4'd15) state_next = ST_READY;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register plus the registered expansion-unit handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            ke_key_byte_reg <= 8'h00;
            ke_load_reg     <= 1'b0;
            ke_start_reg    <= 1'b0;
            rk_err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ke_load_reg  <= key_fire;
            ke_start_reg <= (state_reg == ST_LOAD) && (state_next == ST_EXPAND);
            rk_err_reg   <= (state_reg == ST_READY) && !key_fire && rk_req && (rk_round > MAX_ROUND);
            if (key_fire) begin
                ke_key_byte_reg <= key_byte;
            end
        end
    end

    // Byte counters for key load, expansion capture and serving.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_cnt_reg   <= 4'd0;
            exp_cnt_reg   <= 8'd0;
            srv_cnt_reg   <= 4'd0;
            srv_round_reg <= 4'd0;
        end else begin
            // The byte that leaves IDLE/READY is byte 0, so LOAD resumes at 1.
            if (key_fire) begin
                key_cnt_reg <= (state_reg == ST_LOAD) ? key_cnt_reg + 4'd1 : 4'd1;
            end
            if ((state_reg == ST_LOAD) && (state_next == ST_EXPAND)) begin
                exp_cnt_reg <= 8'd0;
            end else if (exp_fire) begin
                exp_cnt_reg <= (exp_cnt_reg == EXP_LAST) ? 8'd0 : exp_cnt_reg + 8'd1;
            end
            if (req_ok) begin
                srv_round_reg <= rk_round;
            end
            if (state_reg == ST_SERVE) begin
                srv_cnt_reg <= srv_cnt_reg + 4'd1;
            end
        end
    end

    // Store write port: key bytes go to round 0, expansion bytes to rounds 1..NR.
    always_comb begin
        st_wr_en    = key_fire || exp_fire;
        st_wr_round = 4'd1 + exp_cnt_reg[7:4];
        st_wr_idx   = exp_cnt_reg[3:0];
        st_wr_data  = ke_byte;
        if (key_fire) begin
            st_wr_round = 4'd0;
            st_wr_idx   = (state_reg == ST_LOAD) ? key_cnt_reg : 4'd0;
            st_wr_data  = key_byte;
        end
    end

    // Store read port runs one byte ahead so the registered read meets latency 1.
    always_comb begin
        st_rd_round = rk_round;
        st_rd_idx   = 4'd0;
        if (state_reg == ST_SERVE) begin
            st_rd_round = srv_round_reg;
            st_rd_idx   = srv_cnt_reg + 4'd1;
        end
    end

    aes_rk_store #(
        .NUM_ROUNDS (NR)
    ) u_store (
        .clk      (clk),
        .wr_en    (st_wr_en),
        .wr_round (st_wr_round),
        .wr_idx   (st_wr_idx),
        .wr_data  (st_wr_data),
        .rd_round (st_rd_round),
        .rd_idx   (st_rd_idx),
        .rd_data  (st_rd_data)
    );

endmodule

// File: tb/tb_aes_round_key_scheduler.sv
// Self-checking bench for aes_round_key_scheduler. A behavioural AES-128 key
// expansion (S-box derived from GF(2^8) inversion) acts as the byte-serial
// expansion unit and as the reference for every served round key.
module tb_aes_round_key_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_byte = 8'h00;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [7:0] ke_key_byte;
    logic       ke_load;
    logic       ke_start;
    logic [7:0] ke_byte = 8'h00;
    logic       ke_valid = 1'b0;
    logic       rk_req = 1'b0;
    logic [3:0] rk_round = 4'd0;
    logic [7:0] rk_byte;
    logic       rk_valid;
    logic       rk_last;
    logic       rk_err;
    logic       keys_valid;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox [256];
    logic [127:0] model_rk [11];
    logic [127:0] cap_key = 128'h0;

    aes_round_key_scheduler #(.NR(10), .KEY_BYTES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_byte    (key_byte),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .ke_key_byte (ke_key_byte),
        .ke_load     (ke_load),
        .ke_start    (ke_start),
        .ke_byte     (ke_byte),
        .ke_valid    (ke_valid),
        .rk_req      (rk_req),
        .rk_round    (rk_round),
        .rk_byte     (rk_byte),
        .rk_valid    (rk_valid),
        .rk_last     (rk_last),
        .rk_err      (rk_err),
        .keys_valid  (keys_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Expansion-unit side: shift in every key byte handed over on ke_load.
    always @(negedge clk) begin
        if (ke_load) cap_key <= {cap_key[119:0], ke_key_byte};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Feed the 16 key bytes; optionally with idle gaps and a colliding rk_req on byte 0.
    task automatic drive_key(input logic [127:0] key, input bit gaps, input bit collide, input string tag);
        int gap;
        for (int b = 0; b < 16; b++) begin
            gap = gaps ? $urandom_range(0, 2) : 0;
            repeat (gap) begin
                key_valid = 1'b0;
                key_byte = 8'($urandom);
                tick();
            end
            key_valid = 1'b1;
            key_byte = key[127 - 8 * b -: 8];
            if (collide && b == 0) begin
                rk_req = 1'b1;
                rk_round = 4'($urandom_range(0, 10));
            end
            tick();
            rk_req = 1'b0;
            if (collide && b == 0) begin
                chk({tag, "_collide"}, {rk_valid, rk_err, keys_valid, busy}, 4'b0001);
            end
        end
        key_valid = 1'b0;
        chk({tag, "_ke_start"}, {ke_start, busy, key_ready}, 3'b110);
    endtask

    // Behave as the expansion unit: stream rounds 1..10 with random gaps.
    task automatic run_expand(input string tag);
        int gap;
        for (int i = 0; i < 160; i++) begin
            gap = (i == 0) ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
            repeat (gap) begin
                ke_valid = 1'b0;
                ke_byte = 8'($urandom);
                tick();
                if (i == 0) begin
                    chk({tag, "_ke_key"}, cap_key, model_rk[0]);
                    chk({tag, "_ke_start_pulse"}, ke_start, 1'b0);
                    i = i;
                end
            end
            ke_valid = 1'b1;
            ke_byte = model_rk[1 + i / 16][127 - 8 * (i % 16) -: 8];
            tick();
            if (i == 80) chk({tag, "_mid_expand"}, {busy, keys_valid, key_ready}, 3'b100);
        end
        ke_valid = 1'b0;
        ke_byte = 8'($urandom);
        chk({tag, "_ready"}, {keys_valid, busy, key_ready}, 3'b101);
    endtask

    // Request one round and check all 16 served bytes plus the exit to READY.
    task automatic serve_check(input int r, input logic [127:0] exp, input string tag);
        rk_req = 1'b1;
        rk_round = 4'(r);
        tick();
        rk_req = 1'b0;
        rk_round = 4'($urandom);
        chk({tag, "_latency"}, rk_valid, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_b%0d", tag, k), {rk_valid, rk_last, rk_byte},
                {1'b1, (k == 15), exp[127 - 8 * k -: 8]});
            tick();
        end
        chk({tag, "_done"}, {rk_valid, rk_byte, keys_valid, key_ready}, {1'b0, 8'h00, 2'b11});
    endtask

    initial begin
        logic [127:0] k;
        int r;

        build_sbox();

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("reset", {key_ready, keys_valid, busy, rk_valid, rk_last, rk_err, ke_load, ke_start, rk_byte}, 16'h8000);
        rst = 1'b0;

        // 1: FIPS-197 key, full expansion, round 10
        k = 128'h000102030405060708090a0b0c0d0e0f;
        expand_model(k);
        drive_key(k, 1'b0, 1'b0, "t1");
        run_expand("t1");
        serve_check(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "t1_r10");

        // 2: round 0 returns the cipher key
        serve_check(0, 128'h000102030405060708090a0b0c0d0e0f, "t2_r0");

        // 3: out-of-range rounds raise a one-cycle error, no data
        for (int n = 0; n < 2; n++) begin
            rk_req = 1'b1;
            rk_round = (n == 0) ? 4'd11 : 4'd15;
            tick();
            rk_req = 1'b0;
            chk($sformatf("t3_err%0d", n), {rk_err, rk_valid}, 2'b10);
            tick();
            chk($sformatf("t3_after%0d", n), {rk_err, rk_valid, keys_valid, key_ready}, 4'b0011);
        end

        // 4: back-to-back requests, second issued in the READY cycle after rk_last
        serve_check(1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "t4_r1");
        serve_check(2, model_rk[2], "t4_r2");

        // 5: reset at the 8th served byte aborts everything
        rk_req = 1'b1;
        rk_round = 4'd3;
        tick();
        rk_req = 1'b0;
        repeat (7) tick();
        chk("t5_b7", {rk_valid, rk_byte}, {1'b1, model_rk[3][71:64]});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_abort", {rk_valid, rk_byte, keys_valid, key_ready, busy}, {1'b0, 8'h00, 3'b010});

        // 6: random key with gaps, then reload from READY with a colliding request
        k = {$urandom, $urandom, $urandom, $urandom};
        expand_model(k);
        drive_key(k, 1'b1, 1'b0, "t6a");
        run_expand("t6a");
        for (int n = 0; n < 3; n++) begin
            r = $urandom_range(0, 10);
            serve_check(r, model_rk[r], $sformatf("t6a_r%0d", r));
        end
        k = {$urandom, $urandom, $urandom, $urandom};
        expand_model(k);
        drive_key(k, 1'b1, 1'b1, "t6b");
        run_expand("t6b");
        for (int n = 0; n <= 10; n++) begin
            serve_check(n, model_rk[n], $sformatf("t6b_r%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
